// File: rtl/multiplier.sv
// Iterative 64x64 -> 128-bit shift-add multiplier with stall-based handshake.
// Operands are reduced to magnitudes on accept, multiplied unsigned over a
// fixed 64 steps, and the sign is reapplied once on the final step.
module multiplier (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          flush,
  input  logic [63:0]   a,
  input  logic [63:0]   b,
  input  logic          a_signed,
  input  logic          b_signed,
  output logic          stallreq,
  output logic          out_valid,
  output logic [63:0]   result_hi,
  output logic [63:0]   result_lo
);

  localparam int unsigned W  = 64;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt;
  logic [PW-1:0] p;
  logic [W-1:0]  b_abs;
  logic          neg;

  logic          accept;
  logic          step;
  logic          last;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    sum;
  logic [PW-1:0] p_step;
  logic [PW-1:0] p_neg;

  assign accept = (state == ST_IDLE) & in_valid & ~flush;
  assign step   = (state == ST_BUSY) & ~flush;
  assign last   = step & (cnt == '0);

  // Magnitudes; 0x8000... negates to itself, which reads correctly as 2^63 unsigned
  assign a_mag = (a_signed & a[W-1]) ? (~a + W'(1)) : a;
  assign b_mag = (b_signed & b[W-1]) ? (~b + W'(1)) : b;

  // One shift-add step: conditional add into the high half, then shift right
  assign sum    = {1'b0, p[PW-1:W]} + (p[0] ? {1'b0, b_abs} : {(W+1){1'b0}});
  assign p_step = {sum, p[W-1:1]};
  assign p_neg  = ~p_step + PW'(1);

  // Stall while a request is being taken or the iteration is running
  assign stallreq = accept | (state == ST_BUSY);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: if (last)   state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // Completion pulse, registered so it depends only on state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == ST_DONE);
    end
  end

  // Operand latch, iteration datapath and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      b_abs     <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (accept) begin
      p     <= {{W{1'b0}}, a_mag};
      b_abs <= b_mag;
      neg   <= (a_signed & a[W-1]) ^ (b_signed & b[W-1]);
      cnt   <= CW'(W - 1);
    end else if (step) begin
      p   <= p_step;
      cnt <= cnt - CW'(1);
      if (last) begin
        {result_hi, result_lo} <= neg ? p_neg : p_step;
      end
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: cycle-level reference model checked every
// cycle, plus directed operations with hand-computed products.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic        stallreq;
  logic        out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1..64 iterating, 65 completion cycle
  int           m_cnt = 0;
  logic [127:0] m_exp = '0;
  logic [127:0] m_res = '0;

  multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .stallreq  (stallreq),
    .out_valid (out_valid),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_prod(input logic [63:0] x, input logic [63:0] y,
                                            input logic xs, input logic ys);
    logic signed [127:0] ex;
    logic signed [127:0] ey;
    ex = xs ? {{64{x[63]}}, x} : {64'b0, x};
    ey = ys ? {{64{y[63]}}, y} : {64'b0, y};
    return 128'(ex * ey);
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model update
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_res <= '0;
    end else if (flush) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (in_valid) begin
        m_cnt <= 1;
        m_exp <= ref_prod(a, b, a_signed, b_signed);
      end
    end else if (m_cnt == 64) begin
      m_cnt <= 65;
      m_res <= m_exp;
    end else if (m_cnt == 65) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = (m_cnt == 0 && in_valid && !flush) || (m_cnt >= 1 && m_cnt <= 64);
    check("stallreq", 128'(stallreq), 128'(exp_stall));
    check("out_valid", 128'(out_valid), 128'(m_cnt == 65));
    check("result", {result_hi, result_lo}, m_res);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation (caller is at posedge+2 with unit idle) and wait for completion
  task automatic run_op(input string nm, input logic [63:0] x, input logic [63:0] y,
                        input logic xs, input logic ys,
                        input logic [63:0] eh, input logic [63:0] el);
    int stall_n;
    bit seen;
    stall_n = 0;
    seen = 1'b0;
    check({nm, " model"}, ref_prod(x, y, xs, ys), {eh, el});
    a = x; b = y; a_signed = xs; b_signed = ys;
    in_valid = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else if (stallreq) stall_n++;
    end
    check({nm, " done"}, 128'(seen), 128'(1));
    check({nm, " hi"}, 128'(result_hi), 128'(eh));
    check({nm, " lo"}, 128'(result_lo), 128'(el));
    check({nm, " stall cycles"}, 128'(stall_n), 128'(65));
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ov_n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset stallreq", 128'(stallreq), 128'(0));
    check("reset result", {result_hi, result_lo}, 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    run_op("u3x5", 64'd3, 64'd5, 1'b0, 1'b0, 64'd0, 64'hF);
    run_op("umax", '1, '1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
    run_op("s-2x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("smin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
           64'h4000_0000_0000_0000, 64'h0);
    run_op("su-1x2", '1, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("uu-1x2", '1, 64'd2, 1'b0, 1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE);

    // Flush mid-operation; in_valid drops during BUSY and must be ignored
    a = 64'd7; b = 64'd9; a_signed = 1'b0; b_signed = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush stallreq", 128'(stallreq), 128'(0));
    check("flush result held", {result_hi, result_lo}, {64'h1, 64'hFFFF_FFFF_FFFF_FFFE});
    ov_n = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) ov_n++;
    end
    check("flush no out_valid", 128'(ov_n), 128'(0));
    tick();

    // Flush beats in_valid while idle
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush idle stallreq", 128'(stallreq), 128'(0));
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush idle not accepted", 128'(stallreq), 128'(0));
    tick();

    run_op("u2x4", 64'd2, 64'd4, 1'b0, 1'b0, 64'd0, 64'd8);

    // Asynchronous reset mid-operation
    a = 64'd11; b = 64'd13;
    in_valid = 1'b1;
    repeat (30) tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async rst stallreq", 128'(stallreq), 128'(0));
    check("async rst out_valid", 128'(out_valid), 128'(0));
    check("async rst result", {result_hi, result_lo}, 128'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    ov_n = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) ov_n++;
    end
    check("rst no out_valid", 128'(ov_n), 128'(0));
    tick();

    // Back-to-back: in_valid stays high through DONE, next accept in the following IDLE
    run_op("b2b1", 64'd3, 64'd5, 1'b0, 1'b0, 64'd0, 64'hF);
    run_op("b2b2", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Iterative 64x64 -> 128-bit shift-add multiplier for the execute stage; the multiply-side counterpart of the restoring divider, sharing its stall-based pipeline handshake. It accepts one operation per request, supports signed and unsigned operands independently so one unit serves MUL/MULH/MULHU/MULHSU, and holds the pipeline through a fixed 64-cycle iteration. The full 128-bit product is returned with a one-cycle valid pulse.

## Interface
- No parameters; width fixed at 64.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request present; held high by EX until stallreq drops
- flush  in  1  synchronous abort of any in-flight operation
- a  in  64  multiplicand
- b  in  64  multiplier
- a_signed  in  1  treat a as two's complement
- b_signed  in  1  treat b as two's complement
- stallreq  out  1  pipeline stall request, combinational
- out_valid  out  1  one-cycle pulse, product valid
- result_hi  out  64  product bits [127:64]
- result_lo  out  64  product bits [63:0]

## Operation
- States: IDLE, BUSY, DONE; 6-bit iteration counter cnt; 128-bit accumulator P; latched |b| (64b); latched neg flag.
- IDLE, in_valid=1, flush=0: latch |a| into P[63:0], P[127:64]=0, |b|, neg=(a_signed&a[63])^(b_signed&b[63]); cnt=63; go BUSY.
- Absolute value: operand negated (two's complement) only when its signed flag and bit 63 are both set; 0x8000_0000_0000_0000 maps to unsigned 2^63, no overflow.
- BUSY step: sum[64:0] = P[127:64] + (P[0] ? |b| : 0); P <= {sum[64:0], P[63:1]}; cnt decrements.
- On step with cnt==0: result <= neg ? (~P_next + 1) : P_next (128-bit negate); go DONE.
- DONE: out_valid=1 for this cycle; unconditionally return to IDLE next edge; in_valid ignored in DONE (belongs to retiring instruction).
- result_hi/lo hold their value until the next completion; they are not cleared on accept.
- No early termination: zero operands still take 64 steps.
- flush=1: any state -> IDLE next edge; result registers and out_valid not updated; flush wins over in_valid in IDLE.

## Timing
- Reset (rst_n=0, async): state=IDLE, cnt=0, P=0, result_hi=0, result_lo=0, out_valid=0, neg=0.
- stallreq = (state==IDLE & in_valid & ~flush) | (state==BUSY); out_valid = (state==DONE) registered-decoded, no combinational path from inputs.
- Accept in cycle T (IDLE): BUSY cycles T+1..T+64; DONE at T+65 with out_valid=1, stallreq=0, result valid.
- stallreq high T..T+64 inclusive (65 cycles), low at T+65.
- Back-to-back: next request earliest accepted at T+66 (IDLE) -> 66-cycle issue interval.
- Reset asserted mid-BUSY: immediate return to reset values, no out_valid.
- in_valid dropping during BUSY: ignored, operation completes.

## Test plan
- Unsigned a=3, b=5, flags 0 -> at T+65 out_valid=1, result_hi=0, result_lo=0xF; stallreq high exactly T..T+64.
- Unsigned a=b=0xFFFF_FFFF_FFFF_FFFF -> result_hi=0xFFFF_FFFF_FFFF_FFFE, result_lo=0x0000_0000_0000_0001.
- Signed a=0xFFFF_FFFF_FFFF_FFFE (-2), b=3 -> result_hi=0xFFFF_FFFF_FFFF_FFFF, result_lo=0xFFFF_FFFF_FFFF_FFFA; signed a=b=0x8000_0000_0000_0000 -> result_hi=0x4000_0000_0000_0000, result_lo=0.
- Mixed a_signed=1 a=-1, b_signed=0 b=2 -> result_hi=all ones, result_lo=0xFFFF_FFFF_FFFF_FFFE; same operands both unsigned -> result_hi=1, result_lo=0xFFFF_FFFF_FFFF_FFFE.
- flush at T+20 after accepting 7*9 -> IDLE at T+21, stallreq=0, no out_valid, result regs keep prior value; fresh 2*4 then yields result_lo=8 after 65 cycles.
- rst_n low at T+30 mid-op, in_valid held high in DONE cycle -> async clear of all outputs; DONE-cycle in_valid not re-accepted, new accept only in following IDLE cycle.
